reg_writeback: RTL and testbench



---
 rtl/hlcpu_pkg.sv | 17 +
 rtl/wb_queue_mem.sv | 53 +++++
 rtl/reg_writeback.sv | 188 ++++++++++++++++++
 tb/tb_reg_writeback.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hlcpu_pkg.sv
// Shared definitions for the writeback path: datapath widths, the discard
// register number and the queued-result record.
package hlcpu_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  // Writes to this register are discarded by the register file.
  localparam logic [SEL_W-1:0] ZERO_REG = 4'd0;

  // One queued result: destination select plus value.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_mem.sv
// Storage for the writeback queue: DEPTH entries, two write ports and two
// combinational read ports (head and head+1). Pointer management lives in
// reg_writeback. With REG_WRITEBACK_BYPASS_EN defined, every entry is also
// exported so the parent can search the queue.
module wb_queue_mem #(
  parameter int EW    = 20,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [EW-1:0] wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [EW-1:0] wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  output logic [EW-1:0] rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [EW-1:0] rdata1_o
`ifdef REG_WRITEBACK_BYPASS_EN
  ,
  output logic [EW-1:0] ents_o [DEPTH]
`endif
);

  logic [EW-1:0] mem_q [DEPTH];

  // Entry storage; the two write addresses are always distinct when both fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we0_i) begin
        mem_q[waddr0_i] <= wdata0_i;
      end
      if (we1_i) begin
        mem_q[waddr1_i] <= wdata1_i;
      end
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

`ifdef REG_WRITEBACK_BYPASS_EN
  assign ents_o = mem_q;
`endif

endmodule

// File: rtl/reg_writeback.sv
// Writeback buffer between execution units and the register file.
// Accepts up to two results per cycle into an in-order queue and drains up
// to two per cycle onto the regfile write ports; a same-register pair at the
// head retires over two cycles so program order is kept.
// Optional feature macro: REG_WRITEBACK_BYPASS_EN (queue lookup port).
module reg_writeback
  import hlcpu_pkg::*;
#(
  parameter int DATA_W = hlcpu_pkg::DATA_W,
  parameter int SEL_W  = hlcpu_pkg::SEL_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    res0_valid,
  output logic                    res0_ready,
  input  logic [SEL_W-1:0]        res0_sel,
  input  logic [DATA_W-1:0]       res0_data,
  input  logic                    res1_valid,
  output logic                    res1_ready,
  input  logic [SEL_W-1:0]        res1_sel,
  input  logic [DATA_W-1:0]       res1_data,
  output logic [SEL_W-1:0]        wr1_sel,
  output logic [DATA_W-1:0]       wr1_data,
  output logic [SEL_W-1:0]        wr2_sel,
  output logic [DATA_W-1:0]       wr2_data,
  output logic [$clog2(DEPTH):0]  count
`ifdef REG_WRITEBACK_BYPASS_EN
  ,
  input  logic [SEL_W-1:0]        byp_sel,
  output logic                    byp_hit,
  output logic [DATA_W-1:0]       byp_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = SEL_W + DATA_W;
  localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(ZERO_REG);

  // Queue pointers and occupancy
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Head-side read data and drain decision
  logic [AW-1:0] head_nx_s;
  logic [EW-1:0] head_ent_s, next_ent_s;
  logic [1:0]    pops_s;

  // Admission and enqueue
  logic [CW:0]   free_s;
  logic          push0_s, push1_s;
  logic [1:0]    pushes_s;
  logic          we0_s, we1_s;
  logic [AW-1:0] waddr0_s, waddr1_s;
  logic [EW-1:0] wdata0_s, wdata1_s;

`ifdef REG_WRITEBACK_BYPASS_EN
  logic [EW-1:0] ents_s [DEPTH];
`endif

  assign head_nx_s = head_q + AW'(1);

  wb_queue_mem #(
    .EW    (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0_i    (we0_s),
    .waddr0_i (waddr0_s),
    .wdata0_i (wdata0_s),
    .we1_i    (we1_s),
    .waddr1_i (waddr1_s),
    .wdata1_i (wdata1_s),
    .raddr0_i (head_q),
    .rdata0_o (head_ent_s),
    .raddr1_i (head_nx_s),
    .rdata1_o (next_ent_s)
`ifdef REG_WRITEBACK_BYPASS_EN
    ,
    .ents_o   (ents_s)
`endif
  );

  // Drain: pick up to two head entries for the write ports, skipping the
  // second when it targets the same register as the first.
  always_comb begin
    pops_s   = 2'd0;
    wr1_sel  = IDLE_SEL;
    wr1_data = '0;
    wr2_sel  = IDLE_SEL;
    wr2_data = '0;
    if ((count_q >= CW'(2)) &&
        (next_ent_s[EW-1 -: SEL_W] != head_ent_s[EW-1 -: SEL_W])) begin
      pops_s   = 2'd2;
      wr1_sel  = head_ent_s[EW-1 -: SEL_W];
      wr1_data = head_ent_s[DATA_W-1:0];
      wr2_sel  = next_ent_s[EW-1 -: SEL_W];
      wr2_data = next_ent_s[DATA_W-1:0];
    end else if (count_q >= CW'(1)) begin
      pops_s   = 2'd1;
      wr1_sel  = head_ent_s[EW-1 -: SEL_W];
      wr1_data = head_ent_s[DATA_W-1:0];
    end else begin
      pops_s   = 2'd0;
    end
  end

  // Admission: slots freed by this cycle's drain count as free, so a full
  // queue keeps accepting at the drain rate.
  always_comb begin
    free_s     = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pops_s);
    res0_ready = (free_s >= (CW+1)'(1));
    if (res0_valid) begin
      res1_ready = (free_s >= (CW+1)'(2));
    end else begin
      res1_ready = (free_s >= (CW+1)'(1));
    end
  end

  // Enqueue: accepted res0 goes to the tail, accepted res1 behind it; a lone
  // res1 takes the tail slot itself.
  always_comb begin
    push0_s  = res0_valid && res0_ready;
    push1_s  = res1_valid && res1_ready;
    pushes_s = {1'b0, push0_s} + {1'b0, push1_s};
    we0_s    = 1'b0;
    waddr0_s = tail_q;
    wdata0_s = {res0_sel, res0_data};
    we1_s    = 1'b0;
    waddr1_s = tail_q + AW'(1);
    wdata1_s = {res1_sel, res1_data};
    if (push0_s) begin
      we0_s = 1'b1;
      we1_s = push1_s;
    end else if (push1_s) begin
      we0_s    = 1'b1;
      wdata0_s = {res1_sel, res1_data};
    end else begin
      we0_s = 1'b0;
    end
  end

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    head_d  = head_q + AW'(pops_s);
    tail_d  = tail_q + AW'(pushes_s);
    count_d = count_q - CW'(pops_s) + CW'(pushes_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef REG_WRITEBACK_BYPASS_EN
  // Bypass lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [AW-1:0] idx_v;
    logic          match_v;
    idx_v    = '0;
    match_v  = 1'b0;
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_v    = head_q + AW'(i);
      match_v  = (CW'(i) < count_q) && (byp_sel != IDLE_SEL) &&
                 (ents_s[idx_v][EW-1 -: SEL_W] == byp_sel);
      byp_hit  = byp_hit | match_v;
      byp_data = match_v ? ents_s[idx_v][DATA_W-1:0] : byp_data;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback. Inputs change 1 ns after
// the rising edge; outputs are sampled in the same window.
module tb_reg_writeback;
  import hlcpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              res0_valid, res1_valid;
  logic              res0_ready, res1_ready;
  logic [SEL_W-1:0]  res0_sel, res1_sel;
  logic [DATA_W-1:0] res0_data, res1_data;
  logic [SEL_W-1:0]  wr1_sel, wr2_sel;
  logic [DATA_W-1:0] wr1_data, wr2_data;
  logic [2:0]        count;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic [SEL_W-1:0]  byp_sel;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
`endif

  int n_checks;
  int n_fail;

  reg_writeback #(.DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res0_valid (res0_valid),
    .res0_ready (res0_ready),
    .res0_sel   (res0_sel),
    .res0_data  (res0_data),
    .res1_valid (res1_valid),
    .res1_ready (res1_ready),
    .res1_sel   (res1_sel),
    .res1_data  (res1_data),
    .wr1_sel    (wr1_sel),
    .wr1_data   (wr1_data),
    .wr2_sel    (wr2_sel),
    .wr2_data   (wr2_data),
    .count      (count)
`ifdef REG_WRITEBACK_BYPASS_EN
    ,
    .byp_sel    (byp_sel),
    .byp_hit    (byp_hit),
    .byp_data   (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input wb_entry_t e0, input logic v1, input wb_entry_t e1);
    res0_valid = v0;
    res0_sel   = e0.sel;
    res0_data  = e0.data;
    res1_valid = v1;
    res1_sel   = e1.sel;
    res1_data  = e1.data;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_ports(input string tag, input logic [2:0] c,
                             input logic [3:0] s1, input logic [15:0] d1,
                             input logic [3:0] s2, input logic [15:0] d2);
    check_eq({tag, ".count"}, 32'(count), 32'(c));
    check_eq({tag, ".wr1_sel"}, 32'(wr1_sel), 32'(s1));
    check_eq({tag, ".wr1_data"}, 32'(wr1_data), 32'(d1));
    check_eq({tag, ".wr2_sel"}, 32'(wr2_sel), 32'(s2));
    check_eq({tag, ".wr2_data"}, 32'(wr2_data), 32'(d2));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
`ifdef REG_WRITEBACK_BYPASS_EN
    byp_sel = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_ports("reset", 3'd0, 4'd0, 16'h0000, 4'd0, 16'h0000);
    rst_n = 1'b1;
    #1;
    check_eq("reset.res0_ready", 32'(res0_ready), 32'd1);
    check_eq("reset.res1_ready", 32'(res1_ready), 32'd1);

    // Dual distinct results in one cycle retire together next cycle.
    drive(1'b1, '{sel: 4'd1, data: 16'hDEAD}, 1'b1, '{sel: 4'd2, data: 16'hBEEF});
    step();
    idle();
    check_ports("dual", 3'd2, 4'd1, 16'hDEAD, 4'd2, 16'hBEEF);
    step();
    check_ports("dual.after", 3'd0, 4'd0, 16'h0000, 4'd0, 16'h0000);

    // Same-register pair retires over two cycles, older first.
    drive(1'b1, '{sel: 4'd3, data: 16'h1111}, 1'b1, '{sel: 4'd3, data: 16'h2222});
    step();
    idle();
    check_ports("same.c1", 3'd2, 4'd3, 16'h1111, 4'd0, 16'h0000);
    step();
    check_ports("same.c2", 3'd1, 4'd3, 16'h2222, 4'd0, 16'h0000);
    step();
    check_eq("same.empty", 32'(count), 32'd0);

    // Fill: every pair targets r6, so only one entry drains per cycle.
    drive(1'b1, '{sel: 4'd6, data: 16'h6001}, 1'b1, '{sel: 4'd6, data: 16'h6002});
    #1;
    check_eq("fill.c0.res1_ready", 32'(res1_ready), 32'd1);
    step();
    check_ports("fill.c1", 3'd2, 4'd6, 16'h6001, 4'd0, 16'h0000);
    drive(1'b1, '{sel: 4'd6, data: 16'h6003}, 1'b1, '{sel: 4'd6, data: 16'h6004});
    #1;
    check_eq("fill.c1.res1_ready", 32'(res1_ready), 32'd1);
    step();
    check_ports("fill.c2", 3'd3, 4'd6, 16'h6002, 4'd0, 16'h0000);
    drive(1'b1, '{sel: 4'd6, data: 16'h6005}, 1'b1, '{sel: 4'd6, data: 16'h6006});
    #1;
    check_eq("fill.c2.res1_ready", 32'(res1_ready), 32'd1);
    step();
    check_ports("fill.c3", 3'd4, 4'd6, 16'h6003, 4'd0, 16'h0000);
    drive(1'b1, '{sel: 4'd6, data: 16'h6007}, 1'b1, '{sel: 4'd6, data: 16'h6008});
    #1;
    check_eq("fill.full.res0_ready", 32'(res0_ready), 32'd1);
    check_eq("fill.full.res1_ready", 32'(res1_ready), 32'd0);
    step();
    idle();
    #1;
    check_eq("fill.lone.res1_ready", 32'(res1_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_ports($sformatf("fill.drain%0d", k), 3'(4 - k), 4'd6, 16'h6004 + 16'(k), 4'd0, 16'h0000);
      step();
    end
    check_ports("fill.empty", 3'd0, 4'd0, 16'h0000, 4'd0, 16'h0000);

    // Only res1 valid: it lands at the head.
    drive(1'b0, '0, 1'b1, '{sel: 4'd5, data: 16'hABCD});
    step();
    idle();
    check_ports("res1only", 3'd1, 4'd5, 16'hABCD, 4'd0, 16'h0000);
    step();

    // Result to the discard register is queued and drained normally.
    drive(1'b1, '{sel: 4'd0, data: 16'h1234}, 1'b0, '0);
    step();
    idle();
    check_ports("zero_reg", 3'd1, 4'd0, 16'h1234, 4'd0, 16'h0000);
    step();
    check_eq("zero_reg.empty", 32'(count), 32'd0);

    // Reset mid-operation with three entries queued.
    drive(1'b1, '{sel: 4'd9, data: 16'h0001}, 1'b1, '{sel: 4'd9, data: 16'h0002});
    step();
    drive(1'b1, '{sel: 4'd9, data: 16'h0003}, 1'b1, '{sel: 4'd9, data: 16'h0004});
    step();
    idle();
    check_ports("midrst.pre", 3'd3, 4'd9, 16'h0002, 4'd0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_ports("midrst.asserted", 3'd0, 4'd0, 16'h0000, 4'd0, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    check_ports("midrst.after1", 3'd0, 4'd0, 16'h0000, 4'd0, 16'h0000);
    step();
    check_ports("midrst.after2", 3'd0, 4'd0, 16'h0000, 4'd0, 16'h0000);

`ifdef REG_WRITEBACK_BYPASS_EN
    // Bypass returns the youngest queued value for a register.
    drive(1'b1, '{sel: 4'd4, data: 16'h0001}, 1'b1, '{sel: 4'd4, data: 16'h0002});
    step();
    idle();
    byp_sel = 4'd4;
    #1;
    check_eq("byp.hit", 32'(byp_hit), 32'd1);
    check_eq("byp.data", 32'(byp_data), 32'h0002);
    byp_sel = 4'd0;
    #1;
    check_eq("byp.zero.hit", 32'(byp_hit), 32'd0);
    check_eq("byp.zero.data", 32'(byp_data), 32'h0000);
    byp_sel = 4'd5;
    #1;
    check_eq("byp.miss.hit", 32'(byp_hit), 32'd0);
    byp_sel = 4'd4;
    step();
    check_eq("byp.one.hit", 32'(byp_hit), 32'd1);
    check_eq("byp.one.data", 32'(byp_data), 32'h0002);
    step();
    check_eq("byp.empty.hit", 32'(byp_hit), 32'd0);
    byp_sel = 4'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
